standoff_round_ctrl: RTL and testbench



---
 rtl/standoff_pkg.sv | 37 +++
 rtl/standoff_round_ctrl_if.sv | 27 ++
 rtl/standoff_player.sv | 65 ++++++
 rtl/standoff_round_ctrl.sv | 151 +++++++++++++++
 tb/tb_standoff_round_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/standoff_pkg.sv
// rtl/standoff_pkg.sv - action codes, FSM states and winner encodings for the standoff game
package standoff_pkg;

    // 4-bit seven-segment display codes for a player's action
    typedef logic [3:0] code_t;
    localparam code_t ACT_IDLE   = 4'd10;   // dash
    localparam code_t ACT_DUCK   = 4'd11;
    localparam code_t ACT_RELOAD = 4'd12;
    localparam code_t ACT_SHOOT  = 4'd13;
    localparam code_t ACT_BLANK  = 4'd15;

    // round controller states
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CHOOSE    = 3'd1;
    localparam logic [2:0] ST_RESOLVE   = 3'd2;
    localparam logic [2:0] ST_REVEAL    = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // lives never wrap below zero
    function automatic logic [1:0] lose_life(input logic [1:0] lives, input logic hit);
        return (hit && lives != 2'd0) ? lives - 2'd1 : lives;
    endfunction

    function automatic winner_t winner_of(input logic [1:0] l1, input logic [1:0] l2);
        if (l1 == 2'd0 && l2 == 2'd0) return WIN_DRAW;
        if (l1 != 2'd0)               return WIN_P1;
        return WIN_P2;
    endfunction

endpackage

// File: rtl/standoff_round_ctrl_if.sv
// rtl/standoff_round_ctrl_if.sv - start/action pulses in, display and game status out
// master: drives start and the six player pulses, observes the display/status fields
// slave : the round controller
interface standoff_round_ctrl_if;
    logic       start;
    logic       p1_duck, p1_reload, p1_shoot;
    logic       p2_duck, p2_reload, p2_shoot;
    logic [3:0] p1_dchoice, p2_dchoice;
    logic [1:0] p1lives, p2lives;
    logic [1:0] p1_ammo, p2_ammo;
    logic       p1_locked, p2_locked;
    logic       round_active;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output start, p1_duck, p1_reload, p1_shoot, p2_duck, p2_reload, p2_shoot,
        input  p1_dchoice, p2_dchoice, p1lives, p2lives, p1_ammo, p2_ammo,
               p1_locked, p2_locked, round_active, game_over, winner
    );

    modport slave (
        input  start, p1_duck, p1_reload, p1_shoot, p2_duck, p2_reload, p2_shoot,
        output p1_dchoice, p2_dchoice, p1lives, p2lives, p1_ammo, p2_ammo,
               p1_locked, p2_locked, round_active, game_over, winner
    );
endinterface

// File: rtl/standoff_player.sv
// rtl/standoff_player.sv - per-player choice latch, lock flag and ammo register
// inputs : clk, rst, new_game/new_round clears, choosing/resolving phase flags, action pulses
// outputs: locked, lock_next (locked after this edge), eff_action (misfire-adjusted), ammo
module standoff_player
    import standoff_pkg::*;
#(
    parameter int MAX_AMMO = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       new_round,
    input  logic       choosing,
    input  logic       resolving,
    input  logic       duck,
    input  logic       reload,
    input  logic       shoot,
    output logic       locked,
    output logic       lock_next,
    output code_t      eff_action,
    output logic [1:0] ammo
);
    localparam logic [1:0] AMMO_MAX = 2'(MAX_AMMO);

    code_t action;
    code_t pulse_action;
    logic  any_pulse;

    assign any_pulse = duck | reload | shoot;
    assign lock_next = locked | (choosing & any_pulse);

    // simultaneous pulses: shoot beats reload beats duck
    always_comb begin
        pulse_action = ACT_IDLE;
        if (shoot)       pulse_action = ACT_SHOOT;
        else if (reload) pulse_action = ACT_RELOAD;
        else if (duck)   pulse_action = ACT_DUCK;
    end

    // shooting an empty gun is a misfire and counts as doing nothing
    always_comb begin
        eff_action = action;
        if (action == ACT_SHOOT && ammo == 2'd0) eff_action = ACT_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked <= 1'b0;
            action <= ACT_IDLE;
            ammo   <= 2'd0;
        end else if (new_game || new_round) begin
            locked <= 1'b0;
            action <= ACT_IDLE;
            if (new_game) ammo <= 2'd0;
        end else if (choosing && !locked && any_pulse) begin
            locked <= 1'b1;
            action <= pulse_action;
        end else if (resolving) begin
            if (eff_action == ACT_SHOOT)
                ammo <= ammo - 2'd1;
            else if (eff_action == ACT_RELOAD && ammo < AMMO_MAX)
                ammo <= ammo + 2'd1;
        end
    end
endmodule

// File: rtl/standoff_round_ctrl.sv
// rtl/standoff_round_ctrl.sv - standoff round FSM: choose window, resolve, reveal hold, game over
// ports: clk, rst (async, active-high), bus (slave): start, p1/p2 duck/reload/shoot pulses in;
//        p1/p2 dchoice, lives, ammo, locked, round_active, game_over, winner out (all registered)
module standoff_round_ctrl
    import standoff_pkg::*;
#(
    parameter int CHOOSE_CYCLES = 300000000,
    parameter int REVEAL_CYCLES = 200000000,
    parameter int START_LIVES   = 3,
    parameter int MAX_AMMO      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    standoff_round_ctrl_if.slave bus
);
    localparam int TMAX = (CHOOSE_CYCLES > REVEAL_CYCLES) ? CHOOSE_CYCLES : REVEAL_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] CHOOSE_LOAD = TW'(CHOOSE_CYCLES - 1);
    localparam logic [TW-1:0] REVEAL_LOAD = TW'(REVEAL_CYCLES - 1);
    localparam logic [1:0]    LIVES_INIT  = 2'(START_LIVES);

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [1:0]    p1_lives, p2_lives;
    code_t         p1_code, p2_code;
    logic          active_q, over_q;
    winner_t       winner_q;

    logic          choosing, resolving, start_game, next_round;
    logic          p1_locked, p2_locked, p1_lock_next, p2_lock_next;
    code_t         p1_eff, p2_eff;
    logic [1:0]    p1_ammo, p2_ammo;
    logic          p1_hit, p2_hit;

    assign choosing   = (state == ST_CHOOSE);
    assign resolving  = (state == ST_RESOLVE);
    assign start_game = bus.start && (state == ST_IDLE || state == ST_GAME_OVER);
    assign next_round = (state == ST_REVEAL) && (timer == '0)
                        && (p1_lives != 2'd0) && (p2_lives != 2'd0);

    // a duck dodges any shot; two effective shots hit both players
    assign p1_hit = (p2_eff == ACT_SHOOT) && (p1_eff != ACT_DUCK);
    assign p2_hit = (p1_eff == ACT_SHOOT) && (p2_eff != ACT_DUCK);

    standoff_player #(.MAX_AMMO(MAX_AMMO)) u_p1 (
        .clk        (clk),
        .rst        (rst),
        .new_game   (start_game),
        .new_round  (next_round),
        .choosing   (choosing),
        .resolving  (resolving),
        .duck       (bus.p1_duck),
        .reload     (bus.p1_reload),
        .shoot      (bus.p1_shoot),
        .locked     (p1_locked),
        .lock_next  (p1_lock_next),
        .eff_action (p1_eff),
        .ammo       (p1_ammo)
    );

    standoff_player #(.MAX_AMMO(MAX_AMMO)) u_p2 (
        .clk        (clk),
        .rst        (rst),
        .new_game   (start_game),
        .new_round  (next_round),
        .choosing   (choosing),
        .resolving  (resolving),
        .duck       (bus.p2_duck),
        .reload     (bus.p2_reload),
        .shoot      (bus.p2_shoot),
        .locked     (p2_locked),
        .lock_next  (p2_lock_next),
        .eff_action (p2_eff),
        .ammo       (p2_ammo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            p1_lives <= LIVES_INIT;
            p2_lives <= LIVES_INIT;
            p1_code  <= ACT_IDLE;
            p2_code  <= ACT_IDLE;
            active_q <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= WIN_NONE;
        end else begin
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (bus.start) begin
                        state    <= ST_CHOOSE;
                        timer    <= CHOOSE_LOAD;
                        p1_lives <= LIVES_INIT;
                        p2_lives <= LIVES_INIT;
                        p1_code  <= ACT_IDLE;
                        p2_code  <= ACT_IDLE;
                        active_q <= 1'b1;
                        over_q   <= 1'b0;
                        winner_q <= WIN_NONE;
                    end
                end
                ST_CHOOSE: begin
                    // leave as soon as the second lock lands, or when the window runs out
                    if ((p1_lock_next && p2_lock_next) || timer == '0) begin
                        state    <= ST_RESOLVE;
                        active_q <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_RESOLVE: begin
                    state    <= ST_REVEAL;
                    timer    <= REVEAL_LOAD;
                    p1_lives <= lose_life(p1_lives, p1_hit);
                    p2_lives <= lose_life(p2_lives, p2_hit);
                    p1_code  <= p1_eff;
                    p2_code  <= p2_eff;
                end
                ST_REVEAL: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (next_round) begin
                        state    <= ST_CHOOSE;
                        timer    <= CHOOSE_LOAD;
                        p1_code  <= ACT_IDLE;
                        p2_code  <= ACT_IDLE;
                        active_q <= 1'b1;
                    end else begin
                        state    <= ST_GAME_OVER;
                        over_q   <= 1'b1;
                        winner_q <= winner_of(p1_lives, p2_lives);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.p1_dchoice   = p1_code;
    assign bus.p2_dchoice   = p2_code;
    assign bus.p1lives      = p1_lives;
    assign bus.p2lives      = p2_lives;
    assign bus.p1_ammo      = p1_ammo;
    assign bus.p2_ammo      = p2_ammo;
    assign bus.p1_locked    = p1_locked;
    assign bus.p2_locked    = p2_locked;
    assign bus.round_active = active_q;
    assign bus.game_over    = over_q;
    assign bus.winner       = winner_q;
endmodule

// File: tb/tb_standoff_round_ctrl.sv
// tb/tb_standoff_round_ctrl.sv - bench for standoff_round_ctrl
module tb_standoff_round_ctrl;
    localparam int CC = 8;
    localparam int RC = 4;
    localparam int SL = 3;
    localparam int MA = 3;

    localparam int PH_IDLE = 0, PH_CHOOSE = 1, PH_RESOLVE = 2, PH_REVEAL = 3, PH_OVER = 4;

    // stimulus bits: p1 duck/reload/shoot, p2 duck/reload/shoot, start
    localparam logic [6:0] D1 = 7'h01, R1 = 7'h02, S1 = 7'h04;
    localparam logic [6:0] D2 = 7'h08, R2 = 7'h10, S2 = 7'h20, ST = 7'h40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    standoff_round_ctrl_if bus();

    standoff_round_ctrl #(
        .CHOOSE_CYCLES(CC), .REVEAL_CYCLES(RC), .START_LIVES(SL), .MAX_AMMO(MA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- game-level reference model ----------------
    int m_phase, m_cnt, m_win;
    int m_act[2];   // 0 = nothing chosen yet, else chosen code
    int m_lv[2], m_am[2], m_dch[2];

    function automatic int pick(input logic [2:0] p); // {shoot, reload, duck}
        if (p[2]) return 13;
        if (p[1]) return 12;
        if (p[0]) return 11;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_cnt = 0; m_win = 0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_lv[i] = SL; m_am[i] = 0; m_dch[i] = 10;
        end
    endtask

    task automatic model_resolve();
        int e[2];
        for (int i = 0; i < 2; i++)
            e[i] = (m_act[i] == 0 || (m_act[i] == 13 && m_am[i] == 0)) ? 10 : m_act[i];
        for (int i = 0; i < 2; i++) begin
            if (e[1-i] == 13 && e[i] != 11 && m_lv[i] > 0) m_lv[i] = m_lv[i] - 1;
            if (e[i] == 13) m_am[i] = m_am[i] - 1;
            else if (e[i] == 12 && m_am[i] < MA) m_am[i] = m_am[i] + 1;
            m_dch[i] = e[i];
        end
    endtask

    task automatic model_step();
        logic [2:0] pl[2];
        pl[0] = {bus.p1_shoot, bus.p1_reload, bus.p1_duck};
        pl[1] = {bus.p2_shoot, bus.p2_reload, bus.p2_duck};
        case (m_phase)
            PH_IDLE, PH_OVER: if (bus.start) begin
                model_reset();
                m_phase = PH_CHOOSE;
            end
            PH_CHOOSE: begin
                for (int i = 0; i < 2; i++)
                    if (m_act[i] == 0) m_act[i] = pick(pl[i]);
                m_cnt++;
                if ((m_act[0] != 0 && m_act[1] != 0) || m_cnt == CC) m_phase = PH_RESOLVE;
            end
            PH_RESOLVE: begin
                model_resolve();
                m_phase = PH_REVEAL;
                m_cnt = 0;
            end
            PH_REVEAL: begin
                m_cnt++;
                if (m_cnt == RC) begin
                    if (m_lv[0] == 0 || m_lv[1] == 0) begin
                        m_phase = PH_OVER;
                        m_win = (m_lv[0] == 0 && m_lv[1] == 0) ? 3 : (m_lv[0] != 0) ? 1 : 2;
                    end else begin
                        m_phase = PH_CHOOSE;
                        m_cnt = 0;
                        m_act[0] = 0; m_act[1] = 0;
                        m_dch[0] = 10; m_dch[1] = 10;
                    end
                end
            end
            default: m_phase = PH_IDLE;
        endcase
    endtask

    task automatic compare();
        chk("p1_dchoice",   bus.p1_dchoice, m_dch[0]);
        chk("p2_dchoice",   bus.p2_dchoice, m_dch[1]);
        chk("p1lives",      bus.p1lives, m_lv[0]);
        chk("p2lives",      bus.p2lives, m_lv[1]);
        chk("p1_ammo",      bus.p1_ammo, m_am[0]);
        chk("p2_ammo",      bus.p2_ammo, m_am[1]);
        chk("p1_locked",    bus.p1_locked, (m_act[0] != 0) ? 1 : 0);
        chk("p2_locked",    bus.p2_locked, (m_act[1] != 0) ? 1 : 0);
        chk("round_active", bus.round_active, (m_phase == PH_CHOOSE) ? 1 : 0);
        chk("game_over",    bus.game_over, (m_phase == PH_OVER) ? 1 : 0);
        chk("winner",       bus.winner, m_win);
    endtask

    initial begin : model_and_compare
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else     model_step();
            #1;
            compare();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [6:0] v);
        bus.p1_duck = v[0]; bus.p1_reload = v[1]; bus.p1_shoot = v[2];
        bus.p2_duck = v[3]; bus.p2_reload = v[4]; bus.p2_shoot = v[5];
        bus.start   = v[6];
    endtask

    task automatic wait_active(input int limit);
        int n = 0;
        while (!bus.round_active && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_round_active", bus.round_active, 1);
    endtask

    // plays one CHOOSE window, returns CHOOSE cycle count; ends at first REVEAL cycle
    task automatic play(input logic [CC-1:0][6:0] seq, output int cycles);
        wait_active(40);
        cycles = 0;
        for (int c = 0; c < CC; c++) begin
            drive(seq[c]);
            @(negedge clk);
            drive(7'd0);
            cycles++;
            if (!bus.round_active) break;
        end
        chk("left_choose", bus.round_active, 0);
        @(negedge clk);
    endtask

    task automatic chk_round(input int d1, input int d2, input int l1, input int l2,
                             input int a1, input int a2);
        chk("lit_p1_dchoice", bus.p1_dchoice, d1);
        chk("lit_p2_dchoice", bus.p2_dchoice, d2);
        chk("lit_p1lives",    bus.p1lives, l1);
        chk("lit_p2lives",    bus.p2lives, l2);
        chk("lit_p1_ammo",    bus.p1_ammo, a1);
        chk("lit_p2_ammo",    bus.p2_ammo, a2);
    endtask

    task automatic start_pulse();
        drive(ST);
        @(negedge clk);
        drive(7'd0);
    endtask

    initial begin : stimulus
        logic [CC-1:0][6:0] s;
        int cyc;
        int n;
        drive(7'd0);
        repeat (3) @(negedge clk);
        chk_round(10, 10, SL, SL, 0, 0);
        chk("reset_round_active", bus.round_active, 0);
        chk("reset_winner", bus.winner, 0);
        rst = 1'b0;
        @(negedge clk);
        start_pulse();

        // nobody presses; a start inside CHOOSE is ignored; full window runs
        s = '0; s[3] = ST;
        play(s, cyc);
        chk("r1_cycles", cyc, 8);
        chk_round(10, 10, 3, 3, 0, 0);
        drive(S1);                       // pulse during REVEAL is ignored
        @(negedge clk);
        drive(7'd0);
        repeat (3) @(negedge clk);
        chk("r1_next_round_active", bus.round_active, 1);
        chk("r1_next_p1_locked", bus.p1_locked, 0);

        // P1 misfires on empty gun, P2 reloads
        s = '0; s[0] = S1 | R2;
        play(s, cyc);
        chk("r2_cycles", cyc, 1);
        chk_round(10, 12, 3, 3, 0, 1);

        // only P1 acts, late; window times out with P2 idle
        s = '0; s[5] = R1;
        play(s, cyc);
        chk("r3_cycles", cyc, 8);
        chk_round(12, 10, 3, 3, 1, 1);

        // P1 shoots, P2 reloads
        s = '0; s[2] = S1 | R2;
        play(s, cyc);
        chk_round(13, 12, 3, 2, 0, 2);

        // P1 reloads, P2 shoots
        s = '0; s[0] = R1; s[4] = S2;
        play(s, cyc);
        chk_round(12, 13, 2, 2, 1, 1);

        // both shoot
        s = '0; s[1] = S1 | S2;
        play(s, cyc);
        chk_round(13, 13, 1, 1, 0, 0);

        s = '0; s[0] = R1 | R2;
        play(s, cyc);
        chk_round(12, 12, 1, 1, 1, 1);

        s = '0; s[0] = S1 | S2;
        play(s, cyc);
        chk_round(13, 13, 0, 0, 0, 0);
        n = 0;
        while (!bus.game_over && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("go_game_over", bus.game_over, 1);
        chk("go_winner", bus.winner, 3);
        chk("go_reveal_len", n, RC);
        chk_round(13, 13, 0, 0, 0, 0);

        // new game: P1 duck then later shoot; P2 reload+shoot together with no ammo
        start_pulse();
        s = '0; s[0] = D1; s[2] = S1 | R2 | S2;
        play(s, cyc);
        chk("r9_cycles", cyc, 3);
        chk("r9_p1_locked", bus.p1_locked, 1);
        chk("r9_p2_locked", bus.p2_locked, 1);
        chk("r9_winner_cleared", bus.winner, 0);
        chk_round(11, 10, 3, 3, 0, 0);

        s = '0; s[0] = R1 | R2;
        play(s, cyc);
        chk_round(12, 12, 3, 3, 1, 1);

        // same-cycle priorities with ammo: P1 reload beats duck, P2 shoot beats the rest
        s = '0; s[0] = D1 | R1 | D2 | R2 | S2;
        play(s, cyc);
        chk_round(12, 13, 2, 3, 2, 0);

        // reset in the middle of a CHOOSE window after one lock
        wait_active(40);
        drive(D1);
        @(negedge clk);
        drive(7'd0);
        chk("pre_rst_p1_locked", bus.p1_locked, 1);
        rst = 1'b1;
        #1;
        chk("rst_p1_locked", bus.p1_locked, 0);
        chk("rst_round_active", bus.round_active, 0);
        chk("rst_game_over", bus.game_over, 0);
        chk_round(10, 10, 3, 3, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stays_idle", bus.round_active, 0);
        start_pulse();
        s = '0; s[0] = R1 | R2;
        play(s, cyc);
        chk("post_rst_cycles", cyc, 1);
        chk_round(12, 12, 3, 3, 1, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
